ftsd_scan_driver: RTL and testbench

Time-multiplexed driver for the four-digit fourteen-segment display (FTSD). It takes the four 6-bit font codes produced by the display-selection logic (in0 = leftmost digit), snapshots them once per frame and decodes them to segment patterns. It then scans the digits with a guard interval between digits to prevent ghosting. It sits between display-selection logic and the board's FTSD pins.

---
 rtl/ftsd_scan_driver_pkg.sv | 44 ++++
 rtl/ftsd_scan_driver_font_decode.sv | 33 +++
 rtl/ftsd_scan_driver.sv | 142 ++++++++++++++
 tb/tb_ftsd_scan_driver.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ftsd_scan_driver_pkg.sv
// Shared font codes, segment glyphs and scan state type for the FTSD scan driver.
// Glyphs are active-low, segments a..n in bits 0..13, dp in bit 14 (always off).
package ftsd_scan_driver_pkg;

  typedef enum logic {
    DISP  = 1'b0,
    GUARD = 1'b1
  } scan_state_t;

  localparam logic [5:0] FONT_E     = 6'h0E;
  localparam logic [5:0] FONT_I     = 6'h12;
  localparam logic [5:0] FONT_L     = 6'h15;
  localparam logic [5:0] FONT_N     = 6'h17;
  localparam logic [5:0] FONT_O     = 6'h18;
  localparam logic [5:0] FONT_S     = 6'h1C;
  localparam logic [5:0] FONT_W     = 6'h20;
  localparam logic [5:0] FONT_BLANK = 6'h3E;

  // Each glyph is written as the set of lit segments XOR'd out of the all-off word.
  localparam logic [14:0] SEG_BLANK = 15'h7FFF;
  localparam logic [14:0] SEG_0     = SEG_BLANK ^ 15'h0C3F;
  localparam logic [14:0] SEG_1     = SEG_BLANK ^ 15'h0406;
  localparam logic [14:0] SEG_2     = SEG_BLANK ^ 15'h00DB;
  localparam logic [14:0] SEG_3     = SEG_BLANK ^ 15'h008F;
  localparam logic [14:0] SEG_4     = SEG_BLANK ^ 15'h00E6;
  localparam logic [14:0] SEG_5     = SEG_BLANK ^ 15'h00ED;
  localparam logic [14:0] SEG_6     = SEG_BLANK ^ 15'h00FD;
  localparam logic [14:0] SEG_7     = SEG_BLANK ^ 15'h0007;
  localparam logic [14:0] SEG_8     = SEG_BLANK ^ 15'h00FF;
  localparam logic [14:0] SEG_9     = SEG_BLANK ^ 15'h00EF;
  localparam logic [14:0] SEG_W     = SEG_BLANK ^ 15'h2836;
  localparam logic [14:0] SEG_I     = SEG_BLANK ^ 15'h1209;
  localparam logic [14:0] SEG_N     = SEG_BLANK ^ 15'h2136;
  localparam logic [14:0] SEG_L     = SEG_BLANK ^ 15'h0038;
  localparam logic [14:0] SEG_O     = SEG_BLANK ^ 15'h003F;
  localparam logic [14:0] SEG_S     = SEG_BLANK ^ 15'h00ED;
  localparam logic [14:0] SEG_E     = SEG_BLANK ^ 15'h0079;

  // ptr 0 is the leftmost digit, which sits on ftsd_ctl[3].
  function automatic logic [3:0] digit_enable(input logic [1:0] ptr);
    return ~(4'b1000 >> ptr);
  endfunction

endpackage

// File: rtl/ftsd_scan_driver_font_decode.sv
// Combinational font decoder: 6-bit font code to active-low 15-bit segment pattern.
module ftsd_font_decode
  import ftsd_scan_driver_pkg::*;
(
  input  logic [5:0]  code,
  output logic [14:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      6'd0:   seg = SEG_0;
      6'd1:   seg = SEG_1;
      6'd2:   seg = SEG_2;
      6'd3:   seg = SEG_3;
      6'd4:   seg = SEG_4;
      6'd5:   seg = SEG_5;
      6'd6:   seg = SEG_6;
      6'd7:   seg = SEG_7;
      6'd8:   seg = SEG_8;
      6'd9:   seg = SEG_9;
      FONT_W: seg = SEG_W;
      FONT_I: seg = SEG_I;
      FONT_N: seg = SEG_N;
      FONT_L: seg = SEG_L;
      FONT_O: seg = SEG_O;
      FONT_S: seg = SEG_S;
      FONT_E: seg = SEG_E;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ftsd_scan_driver.sv
// Four-digit fourteen-segment scan driver with per-frame input snapshot and guard gaps.
// Optional blinking is compiled in with the FTSD_BLINK_EN macro.
module ftsd_scan_driver
  import ftsd_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV  = 25000,
  parameter int GUARD_CYC = 4,
  parameter int BLINK_DIV = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  in0,
  input  logic [5:0]  in1,
  input  logic [5:0]  in2,
  input  logic [5:0]  in3,
`ifdef FTSD_BLINK_EN
  input  logic        blink,
`endif
  output logic [3:0]  ftsd_ctl,
  output logic [14:0] ftsd_out,
  output logic        frame_start
);

  localparam int MAX_CYC = (SCAN_DIV > GUARD_CYC) ? SCAN_DIV : GUARD_CYC;
  localparam int CW = $clog2(MAX_CYC);
  localparam logic [CW-1:0] SCAN_TC  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GUARD_TC = CW'(GUARD_CYC - 1);

  scan_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [5:0]    snap_q [4];
  logic [5:0]    snap_d [4];
  logic [5:0]    in_vec [4];
  logic          snap_load;
  logic          blank_d;
  logic [14:0]   seg_dec;
  logic [3:0]    ctl_d;
  logic [14:0]   out_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    ptr_d     = ptr_q;
    snap_load = 1'b0;
    case (state_q)
      DISP: begin
        if (cnt_q == SCAN_TC) begin
          state_d = GUARD;
          cnt_d   = '0;
        end
      end
      GUARD: begin
        if (cnt_q == GUARD_TC) begin
          state_d   = DISP;
          cnt_d     = '0;
          ptr_d     = ptr_q + 2'd1;
          snap_load = (ptr_q == 2'd3);
        end
      end
      default: begin
        state_d = GUARD;
        cnt_d   = '0;
      end
    endcase
  end

  // The snapshot feeds the decoder on its load edge so digit 0 shows the fresh code at once.
  always_comb begin
    in_vec[0] = in0;
    in_vec[1] = in1;
    in_vec[2] = in2;
    in_vec[3] = in3;
    for (int i = 0; i < 4; i++) begin
      snap_d[i] = snap_load ? in_vec[i] : snap_q[i];
    end
  end

  ftsd_font_decode u_decode (
    .code (snap_d[ptr_d]),
    .seg  (seg_dec)
  );

`ifdef FTSD_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_DIV - 1);

  logic [BW-1:0] fcnt_q, fcnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (snap_load) begin
      if (fcnt_q == BLINK_TC) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
    end
  end

  assign blank_d = blink & phase_d;
`else
  assign blank_d = 1'b0;
`endif

  assign ctl_d = (state_d == DISP) ? digit_enable(ptr_d) : 4'hF;
  assign out_d = ((state_d == DISP) && !blank_d) ? seg_dec : SEG_BLANK;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= GUARD;
      cnt_q       <= '0;
      ptr_q       <= 2'd3;
      snap_q      <= '{default: '0};
      ftsd_ctl    <= 4'hF;
      ftsd_out    <= SEG_BLANK;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      snap_q      <= snap_d;
      ftsd_ctl    <= ctl_d;
      ftsd_out    <= out_d;
      frame_start <= snap_load;
    end
  end

endmodule

// File: tb/tb_ftsd_scan_driver.sv
// Self-checking bench for ftsd_scan_driver against a frame-arithmetic reference model.
// Exercises blinking as well when FTSD_BLINK_EN is defined.
module tb_ftsd_scan_driver;
  import ftsd_scan_driver_pkg::*;

  localparam int S  = 4;
  localparam int G  = 1;
  localparam int BD = 2;
  localparam int P  = 4 * (S + G);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic [3:0]  ftsd_ctl;
  logic [14:0] ftsd_out;
  logic        frame_start;
`ifdef FTSD_BLINK_EN
  logic        blink = 1'b0;
`endif

  int compared = 0;
  int mismatched = 0;

  int          k = 0;
  int          nfs = 0;
  int          m_pos = -1;
  int          m_slot = 0;
  bit          m_lit = 0;
  logic [5:0]  msnap [4];
  logic [3:0]  e_ctl = 4'hF;
  logic [14:0] e_out = 15'h7FFF;
  logic        e_fs = 1'b0;

  ftsd_scan_driver #(.SCAN_DIV(S), .GUARD_CYC(G), .BLINK_DIV(BD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in0         (in0),
    .in1         (in1),
    .in2         (in2),
    .in3         (in3),
`ifdef FTSD_BLINK_EN
    .blink       (blink),
`endif
    .ftsd_ctl    (ftsd_ctl),
    .ftsd_out    (ftsd_out),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Independent glyph table, written as lit-segment masks.
  function automatic logic [14:0] glyph(input logic [5:0] c);
    case (c)
      6'd0:   return 15'h7FFF ^ 15'h0C3F;
      6'd1:   return 15'h7FFF ^ 15'h0406;
      6'd2:   return 15'h7FFF ^ 15'h00DB;
      6'd3:   return 15'h7FFF ^ 15'h008F;
      6'd4:   return 15'h7FFF ^ 15'h00E6;
      6'd5:   return 15'h7FFF ^ 15'h00ED;
      6'd6:   return 15'h7FFF ^ 15'h00FD;
      6'd7:   return 15'h7FFF ^ 15'h0007;
      6'd8:   return 15'h7FFF ^ 15'h00FF;
      6'd9:   return 15'h7FFF ^ 15'h00EF;
      FONT_W: return 15'h7FFF ^ 15'h2836;
      FONT_I: return 15'h7FFF ^ 15'h1209;
      FONT_N: return 15'h7FFF ^ 15'h2136;
      FONT_L: return 15'h7FFF ^ 15'h0038;
      FONT_O: return 15'h7FFF ^ 15'h003F;
      FONT_S: return 15'h7FFF ^ 15'h00ED;
      FONT_E: return 15'h7FFF ^ 15'h0079;
      default: return 15'h7FFF;
    endcase
  endfunction

  // Advances one clock and derives expected outputs from the cycle count since reset.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      k = 0;
      nfs = 0;
      for (int i = 0; i < 4; i++) msnap[i] = '0;
      m_lit = 0;
      m_pos = -1;
      m_slot = 0;
      e_fs = 1'b0;
    end else begin
      k++;
      m_lit = 0;
      m_pos = -1;
      e_fs = 1'b0;
      if (k >= G) begin
        m_pos = (k - G) % P;
        m_slot = m_pos / (S + G);
        m_lit = (m_pos % (S + G)) < S;
        if (m_pos == 0) begin
          msnap[0] = in0;
          msnap[1] = in1;
          msnap[2] = in2;
          msnap[3] = in3;
          nfs++;
          e_fs = 1'b1;
        end
      end
    end
    e_ctl = 4'hF;
    e_out = 15'h7FFF;
    if (m_lit) begin
      e_ctl[3 - m_slot] = 1'b0;
      e_out = glyph(msnap[m_slot]);
`ifdef FTSD_BLINK_EN
      if (blink && ((nfs / BD) % 2 == 1)) e_out = 15'h7FFF;
`endif
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      compared++;
      if ({ftsd_ctl, ftsd_out, frame_start} !== {4'hF, 15'h7FFF, 1'b0}) begin
        mismatched++;
        $display("[TB] FAIL reset_hold c=%0d: ctl=%b out=%h fs=%b, want ctl=1111 out=7fff fs=0", c, ftsd_ctl, ftsd_out, frame_start);
      end
    end
    in0 = 6'd1; in1 = 6'd2; in2 = 6'd3; in3 = 6'd4;
    rst_n = 1'b1;
    for (int c = 0; c < G; c++) tick();
    compared++;
    if ({ftsd_ctl, ftsd_out, frame_start} !== {4'b0111, 15'h7FFF ^ 15'h0406, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL first_digit: ctl=%b out=%h fs=%b, want ctl=0111 out=%h fs=1", ftsd_ctl, ftsd_out, frame_start, 15'h7FFF ^ 15'h0406);
    end
    tick();
    compared++;
    if (frame_start !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL fs_width: fs=%b, want 0", frame_start);
    end
  endtask

  task automatic test_scan_order();
    int last_fs = -1;
    for (int c = 0; c < 3 * P; c++) begin
      tick();
      compared++;
      if ({ftsd_ctl, ftsd_out, frame_start} !== {e_ctl, e_out, e_fs}) begin
        mismatched++;
        $display("[TB] FAIL scan k=%0d: ctl=%b out=%h fs=%b, want ctl=%b out=%h fs=%b", k, ftsd_ctl, ftsd_out, frame_start, e_ctl, e_out, e_fs);
      end
      if (frame_start === 1'b1) begin
        if (last_fs >= 0) begin
          compared++;
          if (k - last_fs != P) begin
            mismatched++;
            $display("[TB] FAIL frame_period: got %0d, want %0d", k - last_fs, P);
          end
        end
        last_fs = k;
      end
    end
  endtask

  task automatic test_snapshot();
    int frames = 0;
    bit found = 0;
    in0 = 6'd1; in1 = 6'd2; in2 = 6'd3; in3 = 6'd4;
    for (int c = 0; c < 3 * P && !found; c++) begin
      tick();
      if (e_fs) frames++;
      if (frames > 0 && m_lit && m_slot == 1) found = 1;
    end
    if (!found) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL snapshot_wait: digit 1 not reached, got none, want lit");
      return;
    end
    in2 = 6'd7;
    frames = 0;
    for (int c = 0; c < 2 * P; c++) begin
      tick();
      if (e_fs) frames++;
      compared++;
      if ({ftsd_ctl, ftsd_out, frame_start} !== {e_ctl, e_out, e_fs}) begin
        mismatched++;
        $display("[TB] FAIL snapshot k=%0d: ctl=%b out=%h fs=%b, want ctl=%b out=%h fs=%b", k, ftsd_ctl, ftsd_out, frame_start, e_ctl, e_out, e_fs);
      end
      if (m_lit && m_slot == 2) begin
        compared++;
        if (ftsd_out !== ((frames == 0) ? (15'h7FFF ^ 15'h008F) : (15'h7FFF ^ 15'h0007))) begin
          mismatched++;
          $display("[TB] FAIL snapshot_digit2 frame=%0d: out=%h, want %h", frames, ftsd_out, (frames == 0) ? (15'h7FFF ^ 15'h008F) : (15'h7FFF ^ 15'h0007));
        end
      end
    end
  endtask

  task automatic test_letters();
    in0 = FONT_W; in1 = FONT_I; in2 = FONT_N; in3 = 6'h3F;
    for (int c = 0; c < 2 * P + 3; c++) begin
      tick();
      compared++;
      if ({ftsd_ctl, ftsd_out, frame_start} !== {e_ctl, e_out, e_fs}) begin
        mismatched++;
        $display("[TB] FAIL letters k=%0d: ctl=%b out=%h fs=%b, want ctl=%b out=%h fs=%b", k, ftsd_ctl, ftsd_out, frame_start, e_ctl, e_out, e_fs);
      end
      if (c > P && m_lit && m_slot == 3) begin
        compared++;
        if (ftsd_out !== 15'h7FFF) begin
          mismatched++;
          $display("[TB] FAIL unknown_code: out=%h, want 7fff", ftsd_out);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    bit found = 0;
    in0 = 6'd5; in1 = 6'd6; in2 = 6'd8; in3 = 6'd9;
    for (int c = 0; c < 2 * P && !found; c++) begin
      tick();
      if (m_lit && m_slot == 2) found = 1;
    end
    if (!found) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL mid_reset_wait: digit 2 not reached, got none, want lit");
      return;
    end
    rst_n = 1'b0;
    tick();
    compared++;
    if ({ftsd_ctl, ftsd_out, frame_start} !== {4'hF, 15'h7FFF, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_blank: ctl=%b out=%h fs=%b, want ctl=1111 out=7fff fs=0", ftsd_ctl, ftsd_out, frame_start);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < P + 2; c++) begin
      tick();
      compared++;
      if ({ftsd_ctl, ftsd_out, frame_start} !== {e_ctl, e_out, e_fs}) begin
        mismatched++;
        $display("[TB] FAIL restart k=%0d: ctl=%b out=%h fs=%b, want ctl=%b out=%h fs=%b", k, ftsd_ctl, ftsd_out, frame_start, e_ctl, e_out, e_fs);
      end
      if (c == G - 1) begin
        compared++;
        if ({ftsd_ctl, frame_start} !== {4'b0111, 1'b1}) begin
          mismatched++;
          $display("[TB] FAIL restart_first: ctl=%b fs=%b, want ctl=0111 fs=1", ftsd_ctl, frame_start);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] letters [7];
    letters = '{FONT_W, FONT_I, FONT_N, FONT_L, FONT_O, FONT_S, FONT_E};
    for (int c = 0; c < 12 * P; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        logic [5:0] v;
        v = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 63)) : letters[$urandom_range(0, 6)];
        case ($urandom_range(0, 3))
          0: in0 = v;
          1: in1 = v;
          2: in2 = v;
          default: in3 = v;
        endcase
      end
      tick();
      compared++;
      if ({ftsd_ctl, ftsd_out, frame_start} !== {e_ctl, e_out, e_fs}) begin
        mismatched++;
        $display("[TB] FAIL random k=%0d: ctl=%b out=%h fs=%b, want ctl=%b out=%h fs=%b", k, ftsd_ctl, ftsd_out, frame_start, e_ctl, e_out, e_fs);
      end
      compared++;
      if ($countones(~ftsd_ctl) > 1) begin
        mismatched++;
        $display("[TB] FAIL one_digit k=%0d: ctl=%b, want at most one low bit", k, ftsd_ctl);
      end
    end
  endtask

`ifdef FTSD_BLINK_EN
  task automatic test_blink();
    int blanked = 0;
    in0 = 6'd8; in1 = 6'd8; in2 = 6'd8; in3 = 6'd8;
    blink = 1'b1;
    for (int c = 0; c < 8 * P; c++) begin
      tick();
      if (m_lit && ftsd_out === 15'h7FFF) blanked++;
      compared++;
      if ({ftsd_ctl, ftsd_out, frame_start} !== {e_ctl, e_out, e_fs}) begin
        mismatched++;
        $display("[TB] FAIL blink_on k=%0d: ctl=%b out=%h fs=%b, want ctl=%b out=%h fs=%b", k, ftsd_ctl, ftsd_out, frame_start, e_ctl, e_out, e_fs);
      end
    end
    compared++;
    if (blanked == 0) begin
      mismatched++;
      $display("[TB] FAIL blink_effect: blanked lit cycles=%0d, want > 0", blanked);
    end
    blink = 1'b0;
    for (int c = 0; c < 4 * P; c++) begin
      tick();
      compared++;
      if ({ftsd_ctl, ftsd_out, frame_start} !== {e_ctl, e_out, e_fs}) begin
        mismatched++;
        $display("[TB] FAIL blink_off k=%0d: ctl=%b out=%h fs=%b, want ctl=%b out=%h fs=%b", k, ftsd_ctl, ftsd_out, frame_start, e_ctl, e_out, e_fs);
      end
    end
  endtask
`endif

  initial begin
    $display("[TB] ftsd_scan_driver bench start");
    test_reset();
    test_scan_order();
    test_snapshot();
    test_letters();
    test_mid_reset();
    test_random();
`ifdef FTSD_BLINK_EN
    test_blink();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
